// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a single-port word memory.
// Sub-word stores use read-modify-write because the memory has no byte enables.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WORDS_LOG2 = 6
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_STORE,
  input  logic [2:0]            REQ_FUNCT3,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic                  RSP_ERR,
  output logic                  MEM_CS,
  output logic                  MEM_RE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA
);

  localparam int unsigned LA = WORDS_LOG2 + 2;
  localparam logic [DATA_WIDTH-1:0] BYTE_MASK = {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
  localparam logic [DATA_WIDTH-1:0] HALF_MASK = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};

  typedef enum logic [2:0] {
    IDLE, LD_ISSUE, LD_CAP, ST_ISSUE, RMW_RD, RMW_MERGE, RMW_WR, RESP
  } state_t;

  state_t                state, state_nxt;
  logic [2:0]            f3_q;
  logic [LA-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] merge_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_err_q;

  logic                  f3_legal;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  req_err;

  always_comb begin
    f3_legal = 1'b0;
    if (REQ_STORE) begin
      case (REQ_FUNCT3)
        3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
        default:                f3_legal = 1'b0;
      endcase
    end else begin
      case (REQ_FUNCT3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
        default:                                f3_legal = 1'b0;
      endcase
    end
    misaligned   = ((REQ_FUNCT3[1:0] == 2'b01) && REQ_ADDR[0]) ||
                   ((REQ_FUNCT3[1:0] == 2'b10) && (REQ_ADDR[1:0] != 2'b00));
    out_of_range = |REQ_ADDR[ADDR_WIDTH-1:LA];
    req_err      = !f3_legal || misaligned || out_of_range;
  end

  // Little-endian lane select: shift the addressed byte/half down to bit 0.
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] merged;

  assign shamt = {addr_q[1:0], 3'b000};

  always_comb begin
    lane = MEM_RDATA >> shamt;
    case (f3_q)
      3'b000:  load_val = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
      3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
      default: load_val = lane;
    endcase
    lane_mask = (f3_q[0] ? HALF_MASK : BYTE_MASK) << shamt;
    merged    = (MEM_RDATA & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (REQ_VALID) begin
            f3_q       <= REQ_FUNCT3;
            addr_q     <= REQ_ADDR[LA-1:0];
            wdata_q    <= REQ_WDATA;
            rsp_data_q <= '0;
            rsp_err_q  <= req_err;
          end
        end
        LD_CAP:    rsp_data_q <= load_val;
        RMW_MERGE: merge_q    <= merged;
        default: ;
      endcase
    end
  end

  logic                  cs;
  logic [DATA_WIDTH-1:0] wsel;

  always_comb begin
    state_nxt = state;
    REQ_READY = 1'b0;
    cs        = 1'b0;
    MEM_RE    = 1'b1;
    wsel      = '0;
    case (state)
      IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) begin
          if (req_err)                     state_nxt = RESP;
          else if (!REQ_STORE)             state_nxt = LD_ISSUE;
          else if (REQ_FUNCT3 == 3'b010)   state_nxt = ST_ISSUE;
          else                             state_nxt = RMW_RD;
        end
      end
      LD_ISSUE: begin
        cs        = 1'b1;
        state_nxt = LD_CAP;
      end
      LD_CAP:   state_nxt = RESP;
      ST_ISSUE: begin
        cs        = 1'b1;
        MEM_RE    = 1'b0;
        wsel      = wdata_q;
        state_nxt = RESP;
      end
      RMW_RD: begin
        cs        = 1'b1;
        state_nxt = RMW_MERGE;
      end
      RMW_MERGE: state_nxt = RMW_WR;
      RMW_WR: begin
        cs        = 1'b1;
        MEM_RE    = 1'b0;
        wsel      = merge_q;
        state_nxt = RESP;
      end
      RESP: begin
        if (RSP_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Reset blocks memory access and acceptance before the state register clears.
    if (!RST_N) begin
      REQ_READY = 1'b0;
      cs        = 1'b0;
    end

    MEM_CS    = cs;
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    if (cs) begin
      MEM_ADDR[WORDS_LOG2-1:0] = addr_q[LA-1:2];
      MEM_WDATA                = wsel;
    end
  end

  assign RSP_VALID = (state == RESP);
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level reference model, per-cycle
// comparison of handshake and memory-port outputs, bench-side word memory.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_STORE = 1'b0;
  logic [2:0]  REQ_FUNCT3 = '0;
  logic [31:0] REQ_ADDR = '0;
  logic [31:0] REQ_WDATA = '0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic [31:0] RSP_DATA;
  logic        RSP_ERR;
  logic        MEM_CS;
  logic        MEM_RE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;

  load_store_unit #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .WORDS_LOG2(6)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_STORE(REQ_STORE),
    .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .MEM_CS(MEM_CS), .MEM_RE(MEM_RE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] seed_word(input int i);
    return (32'h9E3779B9 * 32'(i + 1)) ^ 32'h5A5A0000;
  endfunction

  // Memory the DUT talks to; read data is garbage except the cycle after a read.
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        mem_init_done = 1'b0;

  always @(posedge CLK) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= seed_word(i);
      mem_init_done <= 1'b1;
      MEM_RDATA <= $urandom;
    end else begin
      if (MEM_CS && MEM_RE) MEM_RDATA <= mem[MEM_ADDR[5:0]];
      else                  MEM_RDATA <= $urandom;
      if (MEM_CS && !MEM_RE) mem[MEM_ADDR[5:0]] <= MEM_WDATA;
    end
  end

  typedef struct packed {
    logic        rst;
    logic        ready;
    logic        cs;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rerr;
  } cyc_t;

  function automatic cyc_t mk(input logic rst, input logic ready, input logic cs, input logic re,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic rvalid, input logic [31:0] rdata, input logic rerr);
    cyc_t c;
    c.rst = rst; c.ready = ready; c.cs = cs; c.re = re; c.addr = addr; c.wdata = wdata;
    c.rvalid = rvalid; c.rdata = rdata; c.rerr = rerr;
    return c;
  endfunction

  function automatic cyc_t rec_idle();                  return mk(0, 1, 0, 1, 0, 0, 0, 0, 0); endfunction
  function automatic cyc_t rec_none();                  return mk(0, 0, 0, 1, 0, 0, 0, 0, 0); endfunction
  function automatic cyc_t rec_rst();                   return mk(1, 0, 0, 1, 0, 0, 0, 0, 0); endfunction
  function automatic cyc_t rec_rd(input int i);         return mk(0, 0, 1, 1, 32'(i), 0, 0, 0, 0); endfunction
  function automatic cyc_t rec_wr(input int i, input logic [31:0] d);
    return mk(0, 0, 1, 0, 32'(i), d, 0, 0, 0);
  endfunction
  function automatic cyc_t rec_resp(input logic [31:0] d, input logic e);
    return mk(0, 0, 0, 1, 0, 0, 1, d, e);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle(input cyc_t e, input string tag);
    cmp({tag, ".req_ready"}, 32'(REQ_READY), 32'(e.ready));
    cmp({tag, ".mem_cs"},    32'(MEM_CS),    32'(e.cs));
    cmp({tag, ".rsp_valid"}, 32'(RSP_VALID), 32'(e.rvalid));
    if (e.cs) begin
      cmp({tag, ".mem_re"},   32'(MEM_RE), 32'(e.re));
      cmp({tag, ".mem_addr"}, MEM_ADDR, e.addr);
      if (!e.re) cmp({tag, ".mem_wdata"}, MEM_WDATA, e.wdata);
    end else begin
      cmp({tag, ".idle_addr"},  MEM_ADDR, 32'h0);
      cmp({tag, ".idle_wdata"}, MEM_WDATA, 32'h0);
      if (!e.rst) cmp({tag, ".mem_re"}, 32'(MEM_RE), 32'h1);
    end
    if (e.rvalid) begin
      cmp({tag, ".rsp_data"}, RSP_DATA, e.rdata);
      cmp({tag, ".rsp_err"},  32'(RSP_ERR), 32'(e.rerr));
    end
  endtask

  cyc_t pre_q[$];
  cyc_t resp_rec;

  // Reference model: decides legality, memory traffic and the response from the rules.
  task automatic plan(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output logic [31:0] word_after);
    int          size, off, idx;
    logic        legal;
    logic [31:0] w, v;
    pre_q.delete();
    idx = int'(a[7:2]);
    off = int'(a[1:0]);
    case (f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      default: size = 4;
    endcase
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    er = !legal || (a >= 32'd256) || ((off % size) != 0);
    rd = 32'h0;
    word_after = ref_mem[idx];
    if (!er) begin
      w = ref_mem[idx];
      if (!st) begin
        v = w >> (8 * off);
        if (size == 1) begin
          v = v & 32'hFF;
          if (f3 == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
        end else if (size == 2) begin
          v = v & 32'hFFFF;
          if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        end
        rd = v;
        pre_q.push_back(rec_rd(idx));
        pre_q.push_back(rec_none());
      end else if (size == 4) begin
        ref_mem[idx] = wd;
        pre_q.push_back(rec_wr(idx, wd));
      end else begin
        for (int i = 0; i < size; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
        ref_mem[idx] = w;
        pre_q.push_back(rec_rd(idx));
        pre_q.push_back(rec_none());
        pre_q.push_back(rec_wr(idx, w));
      end
      word_after = ref_mem[idx];
    end
    resp_rec = rec_resp(rd, er);
  endtask

  task automatic drive_junk();
    REQ_VALID  = 1'($urandom % 2);
    REQ_STORE  = 1'($urandom % 2);
    REQ_FUNCT3 = 3'($urandom % 8);
    REQ_ADDR   = $urandom;
    REQ_WDATA  = $urandom;
  endtask

  task automatic idle_cycle();
    @(negedge CLK);
    check_cycle(rec_idle(), "idle");
    REQ_VALID = 1'b0;
  endtask

  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input int hold, output logic [31:0] mdata, output logic merr,
                         output logic [31:0] mword);
    @(negedge CLK);
    check_cycle(rec_idle(), "accept");
    REQ_VALID  = 1'b1;
    REQ_STORE  = st;
    REQ_FUNCT3 = f3;
    REQ_ADDR   = a;
    REQ_WDATA  = wd;
    RSP_READY  = 1'($urandom % 2);
    plan(st, f3, a, wd, mdata, merr, mword);
    foreach (pre_q[i]) begin
      @(negedge CLK);
      check_cycle(pre_q[i], "busy");
      drive_junk();
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge CLK);
      check_cycle(resp_rec, "resp");
      drive_junk();
      RSP_READY = (h == hold);
    end
  endtask

  logic [31:0] md, mw;
  logic        me;

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = seed_word(i);

    // Reset held with a pending store request.
    RST_N = 1'b0;
    REQ_VALID = 1'b1; REQ_STORE = 1'b1; REQ_FUNCT3 = 3'b010; REQ_ADDR = 32'h8; REQ_WDATA = 32'h12345678;
    repeat (3) begin
      @(negedge CLK);
      check_cycle(rec_rst(), "reset");
    end
    RST_N = 1'b1;
    REQ_VALID = 1'b0;

    run_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, md, me, mw);
    cmp("pin.sw_word", mw, 32'hDEADBEEF);
    run_req(0, 3'b000, 32'h13, 32'h0, 0, md, me, mw);  cmp("pin.lb",  md, 32'hFFFFFFDE);
    run_req(0, 3'b100, 32'h13, 32'h0, 1, md, me, mw);  cmp("pin.lbu", md, 32'h000000DE);
    run_req(0, 3'b001, 32'h12, 32'h0, 0, md, me, mw);  cmp("pin.lh",  md, 32'hFFFFDEAD);
    run_req(0, 3'b101, 32'h10, 32'h0, 2, md, me, mw);  cmp("pin.lhu", md, 32'h0000BEEF);
    run_req(0, 3'b010, 32'h10, 32'h0, 5, md, me, mw);  cmp("pin.lw",  md, 32'hDEADBEEF);
    run_req(1, 3'b000, 32'h11, 32'h000000AA, 0, md, me, mw); cmp("pin.sb_word", mw, 32'hDEADAAEF);
    run_req(1, 3'b001, 32'h12, 32'h00001234, 0, md, me, mw); cmp("pin.sh_word", mw, 32'h1234AAEF);
    run_req(0, 3'b010, 32'h12,  32'h0, 0, md, me, mw); cmp("pin.err_lw_mis",  32'(me), 32'h1);
    run_req(0, 3'b001, 32'h11,  32'h0, 0, md, me, mw); cmp("pin.err_lh_mis",  32'(me), 32'h1);
    run_req(0, 3'b010, 32'h100, 32'h0, 1, md, me, mw); cmp("pin.err_range",   32'(me), 32'h1);
    run_req(0, 3'b011, 32'h10,  32'h0, 0, md, me, mw); cmp("pin.err_funct3",  32'(me), 32'h1);

    // Reset while merging a byte store: no write, no response.
    @(negedge CLK);
    check_cycle(rec_idle(), "rmwrst.accept");
    REQ_VALID = 1'b1; REQ_STORE = 1'b1; REQ_FUNCT3 = 3'b000; REQ_ADDR = 32'h21; REQ_WDATA = 32'h55;
    @(negedge CLK);
    check_cycle(rec_rd(8), "rmwrst.rd");
    REQ_VALID = 1'b0;
    @(negedge CLK);
    check_cycle(rec_none(), "rmwrst.merge");
    RST_N = 1'b0;
    @(negedge CLK);
    check_cycle(rec_rst(), "rmwrst.reset");
    RST_N = 1'b1;
    idle_cycle();
    idle_cycle();
    cmp("rmwrst.word8", mem[8], ref_mem[8]);

    for (int t = 0; t < 300; t++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      st = 1'($urandom % 2);
      f3 = 3'($urandom % 8);
      if ($urandom % 4 != 0) begin
        if (st) f3 = 3'($urandom % 3);
        else begin
          f3 = 3'($urandom % 5);
          if (f3 == 3'd3) f3 = 3'd5;
        end
      end
      a = ($urandom % 16 == 0) ? $urandom : ($urandom % 256);
      if ($urandom % 2 != 0) a = a & ~32'h3;
      run_req(st, f3, a, $urandom, int'($urandom % 4), md, me, mw);
      repeat ($urandom % 3) idle_cycle();
    end

    idle_cycle();
    for (int i = 0; i < 64; i++) cmp($sformatf("final.mem[%0d]", i), mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
